// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: segment patterns (dp clear), dp position,
// capture FSM states and the per-digit filter slot record.
package seven_seg_pkg;

    localparam int unsigned SEG_W  = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned DP_BIT = 7;

    localparam logic [SEG_W-1:0] SEG_0 = 8'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 8'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 8'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 8'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 8'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 8'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 8'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 8'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 8'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 8'h6F;
    localparam logic [SEG_W-1:0] SEG_A = 8'h77;
    localparam logic [SEG_W-1:0] SEG_B = 8'h7C;
    localparam logic [SEG_W-1:0] SEG_C = 8'h39;
    localparam logic [SEG_W-1:0] SEG_D = 8'h5E;
    localparam logic [SEG_W-1:0] SEG_E = 8'h79;
    localparam logic [SEG_W-1:0] SEG_F = 8'h71;

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_PARTIAL = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    // Last pattern seen on a digit slot and its decoded nibble.
    typedef struct packed {
        logic [SEG_W-1:0] last;
        logic [NIB_W-1:0] nib;
    } slot_t;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational seven-segment to hex decode; dp is not part of the pattern.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0]       seg,
    output logic [NIB_W-1:0] nibble,
    output logic             valid
);

    always_comb begin
        nibble = '0;
        valid  = 1'b1;
        case ({1'b0, seg})
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Captures a multiplexed two-digit seven-segment bus, debounces each digit and
// republishes the displayed byte whenever both digits become stable.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEG_W-1:0] seg_in,
    input  logic             dig_idx,
    input  logic             seg_strobe,
    output logic [7:0]       value,
    output logic             value_valid,
    output logic             locked,
    output logic [1:0]       dp_flags,
    output logic             seg_error,
    output logic [7:0]       err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

    logic [NIB_W-1:0] dec_nib;
    logic             dec_valid;
    slot_t            slot_q [2];
    logic [CNT_W-1:0] cnt_q  [2];
    logic [1:0]       lock;
    state_t           state_q, state_d;
    logic             publish_c;

    seven_seg_decode u_decode (
        .seg    (seg_in[6:0]),
        .nibble (dec_nib),
        .valid  (dec_valid)
    );

    assign lock = {cnt_q[1] == CNT_MAX, cnt_q[0] == CNT_MAX};

    // Per-digit stability filter; only the addressed slot moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else if (seg_strobe) begin
            if (!dec_valid) begin
                slot_q[dig_idx].last <= seg_in;
                cnt_q[dig_idx]       <= '0;
            end else if (seg_in == slot_q[dig_idx].last) begin
                if (cnt_q[dig_idx] != CNT_MAX)
                    cnt_q[dig_idx] <= cnt_q[dig_idx] + CNT_W'(1);
            end else begin
                slot_q[dig_idx].last <= seg_in;
                slot_q[dig_idx].nib  <= dec_nib;
                cnt_q[dig_idx]       <= CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_HUNT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        publish_c = 1'b0;
        case (state_q)
            S_HUNT: begin
                if (&lock)      state_d = S_LOCKED;
                else if (|lock) state_d = S_PARTIAL;
            end
            S_PARTIAL: begin
                if (&lock)       state_d = S_LOCKED;
                else if (!(|lock)) state_d = S_HUNT;
            end
            S_LOCKED: begin
                if (!(&lock)) state_d = (|lock) ? S_PARTIAL : S_HUNT;
            end
            default: state_d = S_HUNT;
        endcase
        publish_c = (state_d == S_LOCKED) && (state_q != S_LOCKED);
    end

    // Published byte and dp flags hold their contents across unlocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value       <= '0;
            value_valid <= 1'b0;
            locked      <= 1'b0;
            dp_flags    <= '0;
        end else begin
            value_valid <= publish_c;
            locked      <= (state_d == S_LOCKED);
            if (publish_c) begin
                value    <= {slot_q[1].nib, slot_q[0].nib};
                dp_flags <= {slot_q[1].last[DP_BIT], slot_q[0].last[DP_BIT]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_error <= 1'b0;
            err_count <= '0;
        end else begin
            seg_error <= seg_strobe && !dec_valid;
            if (seg_strobe && !dec_valid && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: strobe vector tables with a publish scoreboard,
// plus a hand-written asynchronous reset sequence.
module tb_seven_seg_capture;

    logic       clk;
    logic       rst_n;
    logic [7:0] seg_in;
    logic       dig_idx;
    logic       seg_strobe;
    logic [7:0] value;
    logic       value_valid;
    logic       locked;
    logic [1:0] dp_flags;
    logic       seg_error;
    logic [7:0] err_count;

    seven_seg_capture #(.STABLE_CNT(4), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_idx     (dig_idx),
        .seg_strobe  (seg_strobe),
        .value       (value),
        .value_valid (value_valid),
        .locked      (locked),
        .dp_flags    (dp_flags),
        .seg_error   (seg_error),
        .err_count   (err_count)
    );

    typedef struct packed {
        logic       idx;
        logic [7:0] seg;
        logic       err;
        logic       lock;
        logic       pub;
        logic [7:0] val;
        logic [1:0] dp;
    } vec_t;

    typedef struct packed {
        logic [7:0] val;
        logic [1:0] dp;
    } pub_t;

    vec_t vecs[$];
    pub_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void add_vec(input logic idx, input logic [7:0] seg, input logic err,
                                    input logic lock, input logic pub,
                                    input logic [7:0] val, input logic [1:0] dp);
        vec_t v;
        v.idx = idx; v.seg = seg; v.err = err; v.lock = lock;
        v.pub = pub; v.val = val; v.dp = dp;
        vecs.push_back(v);
    endfunction

    // One strobe cycle, then check error pulse, then lock state and held outputs.
    task automatic apply(input vec_t v);
        pub_t p;
        if (v.pub) begin
            p.val = v.val;
            p.dp  = v.dp;
            sb.push_back(p);
        end
        @(negedge clk);
        seg_in     = v.seg;
        dig_idx    = v.idx;
        seg_strobe = 1'b1;
        @(negedge clk);
        seg_strobe = 1'b0;
        seg_in     = 8'h00;
        check("seg_error", 32'(seg_error), 32'(v.err));
        @(negedge clk);
        check("locked", 32'(locked), 32'(v.lock));
        check("value", 32'(value), 32'(v.val));
        check("dp_flags", 32'(dp_flags), 32'(v.dp));
    endtask

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
        vecs.delete();
    endtask

    // Publish monitor: every value_valid pulse must match the oldest expected publish.
    always @(negedge clk) begin
        if (value_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_pub", 32'(value), 32'hFFFF_FFFF);
            end else begin
                pub_t p;
                p = sb.pop_front();
                check("pub_value", 32'(value), 32'(p.val));
                check("pub_dp", 32'(dp_flags), 32'(p.dp));
            end
        end
    end

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        seg_in     = 8'h00;
        dig_idx    = 1'b0;
        seg_strobe = 1'b0;
        #3;
        check("rst_value", 32'(value), 32'h00);
        check("rst_valid", 32'(value_valid), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_dp", 32'(dp_flags), 32'h0);
        check("rst_err", 32'(seg_error), 32'h0);
        check("rst_errcnt", 32'(err_count), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // F5 lock, then identical strobes give no extra pulse
        for (int i = 0; i < 3; i++) begin
            add_vec(1, 8'h71, 0, 0, 0, 8'h00, 2'b00);
            add_vec(0, 8'h6D, 0, 0, 0, 8'h00, 2'b00);
        end
        add_vec(1, 8'h71, 0, 0, 0, 8'h00, 2'b00);
        add_vec(0, 8'h6D, 0, 1, 1, 8'hF5, 2'b00);
        add_vec(1, 8'h71, 0, 1, 0, 8'hF5, 2'b00);
        add_vec(0, 8'h6D, 0, 1, 0, 8'hF5, 2'b00);
        // low digit changes to 3: unlock, value holds, relock to F3
        for (int i = 0; i < 3; i++) add_vec(0, 8'h4F, 0, 0, 0, 8'hF5, 2'b00);
        add_vec(0, 8'h4F, 0, 1, 1, 8'hF3, 2'b00);
        // invalid patterns, then requalify to 10
        add_vec(1, 8'h00, 1, 0, 0, 8'hF3, 2'b00);
        add_vec(1, 8'h49, 1, 0, 0, 8'hF3, 2'b00);
        for (int i = 0; i < 4; i++) add_vec(0, 8'h3F, 0, 0, 0, 8'hF3, 2'b00);
        for (int i = 0; i < 3; i++) add_vec(1, 8'h06, 0, 0, 0, 8'hF3, 2'b00);
        add_vec(1, 8'h06, 0, 1, 1, 8'h10, 2'b00);
        // low digit to A with high still 1, then flicker on the high digit
        for (int i = 0; i < 3; i++) add_vec(0, 8'h77, 0, 0, 0, 8'h10, 2'b00);
        add_vec(0, 8'h77, 0, 1, 1, 8'h1A, 2'b00);
        for (int i = 0; i < 3; i++) add_vec(1, 8'h7D, 0, 0, 0, 8'h1A, 2'b00);
        add_vec(1, 8'h7F, 0, 0, 0, 8'h1A, 2'b00);
        for (int i = 0; i < 3; i++) add_vec(1, 8'h7D, 0, 0, 0, 8'h1A, 2'b00);
        add_vec(1, 8'h7D, 0, 1, 1, 8'h6A, 2'b00);
        // dp on the high digit: FA then F5, both with dp flags 10
        for (int i = 0; i < 3; i++) add_vec(1, 8'hF1, 0, 0, 0, 8'h6A, 2'b00);
        add_vec(1, 8'hF1, 0, 1, 1, 8'hFA, 2'b10);
        for (int i = 0; i < 3; i++) add_vec(0, 8'h6D, 0, 0, 0, 8'hFA, 2'b10);
        add_vec(0, 8'h6D, 0, 1, 1, 8'hF5, 2'b10);
        // two of four qualifying strobes before the reset
        add_vec(0, 8'h3F, 0, 0, 0, 8'hF5, 2'b10);
        add_vec(0, 8'h3F, 0, 0, 0, 8'hF5, 2'b10);
        run_vecs();

        check("errcnt_two", 32'(err_count), 32'h02);

        // asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_value", 32'(value), 32'h00);
        check("mid_rst_valid", 32'(value_valid), 32'h0);
        check("mid_rst_locked", 32'(locked), 32'h0);
        check("mid_rst_dp", 32'(dp_flags), 32'h0);
        check("mid_rst_err", 32'(seg_error), 32'h0);
        check("mid_rst_errcnt", 32'(err_count), 32'h00);
        #1 rst_n = 1'b1;

        // counters restart from zero: two more 3F strobes must not lock
        for (int i = 0; i < 4; i++) add_vec(1, 8'h06, 0, 0, 0, 8'h00, 2'b00);
        for (int i = 0; i < 3; i++) add_vec(0, 8'h3F, 0, 0, 0, 8'h00, 2'b00);
        add_vec(0, 8'h3F, 0, 1, 1, 8'h10, 2'b00);
        run_vecs();

        @(negedge clk);
        @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'h0);
        check("final_errcnt", 32'(err_count), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
